// File: rtl/cla_serial_add_ctrl_pkg.sv
// cla_serial_add_ctrl_pkg: shared FSM encodings and slice width for the serial CLA sequencer
package cla_serial_add_ctrl_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Carry_Lookahead_Adder_4_bit.sv
// Carry_Lookahead_Adder_4_bit: combinational 4-bit carry-lookahead adder slice
module Carry_Lookahead_Adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g = A & B;
    p = A ^ B;
    c[0] = Cin;
    c[1] = g[0] | (p[0] & Cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & Cin);
    S = p ^ c[3:0];
    Cout = c[4];
  end
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: nibble-serial add/subtract sequencer around an external 4-bit CLA slice
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy,
  output logic [NIBBLE_W-1:0] cla_a,
  output logic [NIBBLE_W-1:0] cla_b,
  output logic                cla_cin,
  input  logic [NIBBLE_W-1:0] cla_s,
  input  logic                cla_cout
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

  state_t state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic carry_reg, cout_reg, ovf_reg;
  logic [IW-1:0] idx;
  logic last;

  assign last      = idx == IW'(NIBBLES - 1);
  assign in_ready  = state == IDLE;
  assign busy      = state == RUN;
  assign out_valid = state == DONE;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

  always_comb begin
    state_nx = (state == IDLE && in_valid) ? RUN :
               (state == RUN && last)      ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
    cla_a   = busy ? a_reg[NIBBLE_W*idx +: NIBBLE_W] : '0;
    cla_b   = busy ? b_reg[NIBBLE_W*idx +: NIBBLE_W] : '0;
    cla_cin = busy ? carry_reg : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_reg     <= a;
        b_reg     <= sub ? ~b : b;
        carry_reg <= sub ? 1'b1 : cin;
        idx       <= '0;
      end
      if (state == RUN) begin
        sum_reg[NIBBLE_W*idx +: NIBBLE_W] <= cla_s;
        carry_reg <= cla_cout;
        idx       <= idx + 1'b1;
        if (last) begin
          cout_reg <= cla_cout;
          ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit carry-lookahead adder slice (Carry_Lookahead_Adder_4_bit), processing one nibble per cycle LSB-first with a registered ripple carry. It sits between a valid/ready operand source and a valid/ready result sink, so wide arithmetic reuses one small slice.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived localparam; number of slice passes per operation.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand source has a request
in_ready  out  1  controller can accept a request
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add mode only)
sub  in  1  1 = A - B, 0 = A + B + cin
out_valid  out  1  result available
out_ready  in  1  sink accepts result
sum  out  WIDTH  result
cout  out  1  carry out of bit WIDTH-1
ovf  out  1  two's-complement signed overflow
busy  out  1  high in RUN
cla_a  out  4  slice operand A nibble
cla_b  out  4  slice operand B nibble (already inverted for sub)
cla_cin  out  1  slice carry-in
cla_s  in  4  slice sum, combinational from cla_* same cycle
cla_cout  in  1  slice carry-out, combinational

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low. When rst_n=0 at a rising edge, the FSM goes to IDLE and clears the a_reg, b_reg, sum_reg, carry_reg, idx, cout and ovf registers.
- After reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Reset mid-operation aborts the operation with no result emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: a_reg<=a; b_reg<= sub ? ~b : b; carry_reg<= sub ? 1 : cin; idx<=0; go to RUN.
  - cin is ignored when sub=1.
- RUN:
  - in_ready=0, busy=1.
  - cla_a=a_reg[4*idx+:4], cla_b=b_reg[4*idx+:4], cla_cin=carry_reg.
  - Each edge: sum_reg[4*idx+:4]<=cla_s; carry_reg<=cla_cout; idx<=idx+1.
  - When idx==NIBBLES-1: also cout<=cla_cout, ovf<=(a_reg[W-1]==b_reg[W-1]) && (cla_s[3]!=a_reg[W-1]); go to DONE.
- cla_* outside RUN: driven 0.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - Hold until out_ready=1, then go to IDLE. out_valid must not drop before the handshake.
- Latency: an accept at edge T gives RUN during cycles T+1..T+NIBBLES; out_valid is high from cycle T+NIBBLES+1.
- Throughput: in_ready returns the cycle after the output handshake; one operation per NIBBLES+2 cycles minimum.
- in_valid while not in IDLE: ignored, no capture. Source must hold a/b/cin/sub stable until accepted.
- sum/cout/ovf persist after the handshake until the next op's writes.
- WIDTH=4: single RUN cycle.

Decomposition:
- Shared package/header holds: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE_W=4.
- No sub-module inside the controller.
- The parent instantiates the controller plus one Carry_Lookahead_Adder_4_bit, wired cla_a/cla_b/cla_cin to A/B/Cin and S/Cout to cla_s/cla_cout.
- The bench uses the same pairing.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 5 cycles after accept; busy high 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles).
- sub=1, a=0x8000, b=0x0001, cin=1 (ignored) -> sum=0x7FFF, cout=1, ovf=1. Then a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> out_valid and sum held constant, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
- Back-to-back in_valid while busy with different operands -> only the first captured; second accepted when in_ready rises, with correct result.
- rst_n=0 for 1 cycle during RUN (idx=2) -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; a new op afterwards completes correctly.
